// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game blocks.
// LED index width, state encoding and LFSR configuration.
package memory_game_pkg;

  localparam int IDX_W     = 4;
  localparam int NUM_LEDS  = 16;
  localparam int NUM_SLOTS = 6;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } state_t;

  // Lowest index whose used bit is clear.
  function automatic idx_t lowest_free(
    input logic [NUM_LEDS-1:0] used
  );
    idx_t r;
    r = '0;
    for (int i = NUM_LEDS - 1; i >= 0; i--) begin
      if (!used[i]) r = idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// A zero seed would lock up, so it is forced to 1.
module lfsr16
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  localparam logic [15:0] INIT =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!rst) state <= INIT;
    else      state <= {state[14:0], fb};
  end

endmodule

// File: rtl/memory_pair_gen.sv
// Draws six distinct LED indices for the memory game on request.
// Pairs flashed by the game are (a,f), (b,e) and (c,d).
module memory_pair_gen
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_RETRY = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  output logic [IDX_W-1:0] idx_c,
  output logic [IDX_W-1:0] idx_d,
  output logic [IDX_W-1:0] idx_e,
  output logic [IDX_W-1:0] idx_f,
  output logic             done,
  output logic             busy
);

  localparam logic [3:0] RMAX  = 4'(MAX_RETRY);
  localparam logic [2:0] SLAST = 3'(NUM_SLOTS - 1);

  state_t              state, state_nx;
  logic [15:0]         lfsr;
  logic [NUM_LEDS-1:0] used, used_nx;
  logic [2:0]          slot, slot_nx;
  logic [3:0]          retry, retry_nx;
  idx_t                slots [NUM_SLOTS];
  idx_t                cand, fill, pick;
  logic                hit, store;
  logic                unused_lfsr;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign cand        = lfsr[IDX_W-1:0];
  assign unused_lfsr = ^lfsr[15:IDX_W];
  assign hit         = used[cand];
  assign fill        = lowest_free(used);

  always_comb begin
    state_nx = state;
    used_nx  = used;
    slot_nx  = slot;
    retry_nx = retry;
    store    = 1'b0;
    pick     = cand;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_nx = ST_DRAW;
          used_nx  = '0;
          slot_nx  = '0;
          retry_nx = '0;
        end
      end
      ST_DRAW: begin
        unique case (1'b1)
          !hit:                 store = 1'b1;
          hit && retry < RMAX:  retry_nx = retry + 4'd1;
          hit && retry >= RMAX: begin
            store = 1'b1;
            pick  = fill;
          end
        endcase
        if (store) begin
          used_nx  = used | (NUM_LEDS'(1) << pick);
          retry_nx = '0;
          if (slot == SLAST) state_nx = ST_DONE;
          else               slot_nx  = slot + 3'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      used  <= '0;
      slot  <= '0;
      retry <= '0;
    end else begin
      state <= state_nx;
      used  <= used_nx;
      slot  <= slot_nx;
      retry <= retry_nx;
    end
  end

  // Only the slot currently addressed is written; others hold.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!rst)
        slots[i] <= '0;
      else if (store && slot == 3'(i))
        slots[i] <= pick;
    end
  end

  assign idx_a = slots[0];
  assign idx_b = slots[1];
  assign idx_c = slots[2];
  assign idx_d = slots[3];
  assign idx_e = slots[4];
  assign idx_f = slots[5];

  assign done = (state == ST_DONE);
  assign busy = (state == ST_DRAW);

endmodule

// File: tb/tb_memory_pair_gen.sv
// Directed bench for memory_pair_gen, default and zero-retry builds.
// Expected draws come from an independent LFSR and draw model.
module tb_memory_pair_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       req2 = 1'b0;
  logic [3:0] ia [6];
  logic [3:0] ib [6];
  logic       done, busy, done2, busy2;
  logic [15:0] m_lfsr;
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  memory_pair_gen dut (
    .clk   (clk),   .rst   (rst),   .req   (req),
    .idx_a (ia[0]), .idx_b (ia[1]), .idx_c (ia[2]),
    .idx_d (ia[3]), .idx_e (ia[4]), .idx_f (ia[5]),
    .done  (done),  .busy  (busy)
  );

  memory_pair_gen #(.MAX_RETRY(0)) dut2 (
    .clk   (clk),   .rst   (rst),   .req   (req2),
    .idx_a (ib[0]), .idx_b (ib[1]), .idx_c (ib[2]),
    .idx_d (ib[3]), .idx_e (ib[4]), .idx_f (ib[5]),
    .done  (done2), .busy  (busy2)
  );

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= nxt(m_lfsr);
  end

  // Draw as described for a request sampled with lfsr value l0.
  task automatic draw(input logic [15:0] l0, input int maxr,
                      output logic [23:0] o, output int lat);
    logic [15:0] l, used;
    logic [3:0]  c, v;
    int          slot, retry;
    bit          st;
    l = l0; used = '0; slot = 0; retry = 0; lat = 0; o = '0;
    while (slot < 6) begin
      l = nxt(l);
      lat++;
      c = l[3:0];
      st = 1'b0;
      v = c;
      if (!used[c]) st = 1'b1;
      else if (retry < maxr) retry++;
      else begin
        st = 1'b1;
        for (int k = 15; k >= 0; k--)
          if (!used[k]) v = 4'(k);
      end
      if (st) begin
        o[4*slot +: 4] = v;
        used[v] = 1'b1;
        slot++;
        retry = 0;
      end
    end
  endtask

  function automatic bit distinct(input logic [23:0] o);
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (o[4*i +: 4] == o[4*j +: 4]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] obs_a();
    return {ia[5], ia[4], ia[3], ia[2], ia[1], ia[0]};
  endfunction

  function automatic logic [23:0] obs_b();
    return {ib[5], ib[4], ib[3], ib[2], ib[1], ib[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on dut, then compare latency and result.
  task automatic finish_a(input string tag, input logic [23:0] exp,
                          input int lat);
    int n;
    n = 0;
    while (!done && n < 120) begin
      step();
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " lat_range"}, 32'(n >= 6 && n <= 96), 1);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " idx"}, obs_a(), exp);
    chk({tag, " distinct"}, 32'(distinct(obs_a())), 1);
  endtask

  task automatic do_req_a(input string tag);
    logic [23:0] exp;
    int lat;
    draw(m_lfsr, 15, exp, lat);
    req = 1'b1;
    step();
    req = 1'b0;
    chk({tag, " acc_busy"}, busy, 1);
    chk({tag, " acc_done"}, done, 0);
    finish_a(tag, exp, lat);
  endtask

  initial begin
    logic [23:0] exp, exp2, held;
    int lat, lat2, n;

    // Reset with random req activity.
    for (int i = 0; i < 3; i++) begin
      req  = 1'($urandom);
      req2 = 1'($urandom);
      step();
    end
    chk("rst idx_a", obs_a(), 0);
    chk("rst idx_b", obs_b(), 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst done2", done2, 0);
    chk("rst busy2", busy2, 0);
    chk("rst lfsr", dut.u_lfsr.state, 16'hACE1);
    req = 1'b0;
    req2 = 1'b0;
    rst = 1'b1;
    step();

    // Single request, then outputs must hold.
    do_req_a("single");
    held = obs_a();
    for (int i = 0; i < 200; i++) begin
      step();
      if (obs_a() !== held || !done) begin
        chk("hold idx", obs_a(), held);
        chk("hold done", done, 1);
      end
    end
    chk("hold end idx", obs_a(), held);
    chk("hold end done", done, 1);

    // req held through the draw: no restart until DONE.
    draw(m_lfsr, 15, exp, lat);
    req = 1'b1;
    step();
    chk("hold_req acc", busy, 1);
    for (n = 1; n < lat; n++) begin
      step();
      chk("hold_req busy", busy, 1);
      chk("hold_req nodone", done, 0);
    end
    step();
    chk("hold_req done", done, 1);
    chk("hold_req idx", obs_a(), exp);
    draw(m_lfsr, 15, exp2, lat2);
    step();
    chk("restart done", done, 0);
    chk("restart busy", busy, 1);
    req = 1'b0;
    finish_a("restart", exp2, lat2);

    // Reset three cycles into a draw.
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst idx", obs_a(), 0);
    chk("midrst done", done, 0);
    chk("midrst busy", busy, 0);
    chk("midrst lfsr", dut.u_lfsr.state, 16'hACE1);
    rst = 1'b1;
    do_req_a("after_rst");

    // Zero-retry build always finishes in six decisions.
    draw(m_lfsr, 0, exp, lat);
    req2 = 1'b1;
    step();
    req2 = 1'b0;
    chk("fb acc_busy", busy2, 1);
    n = 0;
    while (!done2 && n < 120) begin
      step();
      n++;
    end
    chk("fb latency", n, 6);
    chk("fb idx", obs_b(), exp);
    chk("fb distinct", 32'(distinct(obs_b())), 1);

    // Soak with random spacing between requests.
    for (int k = 0; k < 2000; k++) begin
      repeat ($urandom_range(0, 7)) step();
      do_req_a("soak");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_pair_gen.md
# memory_pair_gen

Pair generator answering the memory game controller's pair request. On each request it draws six distinct LED indices (0–15) from a free-running LFSR and raises a done level once all six are held stable. The indices form the three LED pairs the game flashes and then checks against the switches: (A,F), (B,E) and (C,D).

## Interface
Parameters:
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- MAX_RETRY, 15, rejected draws per slot before the fallback pick.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  pair request; level, sampled only in IDLE or DONE.
- idx_a … idx_f  out  4 each  generated indices; pairs are (a,f), (b,e), (c,d).
- done  out  1  high while idx_a…idx_f are valid and stable.
- busy  out  1  high while drawing.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
  - Advances every cycle in every state, so the result depends on button timing.
  - Candidate value: cand = lfsr[3:0].
- **State machine**
  - States: IDLE, DRAW, DONE.
  - IDLE: req=1 → clear used[15:0], slot=0, retry=0, go to DRAW.
  - DRAW: one decision per cycle.
    - used[cand]=0: store cand into the current slot, set used[cand], slot++, retry=0.
    - used[cand]=1 and retry<MAX_RETRY: retry++, no store.
    - used[cand]=1 and retry==MAX_RETRY: store the lowest-numbered unused index, then behave as an accept.
    - The store that fills slot 5 goes to DONE in the same edge.
  - DONE: done=1, outputs held. req=1 → behave as IDLE with req (restart).
  - req is ignored while in DRAW.
- **Slot order:** slot 0→idx_a, 1→idx_b, 2→idx_c, 3→idx_d, 4→idx_e, 5→idx_f.
- **Output rules**
  - The six outputs are always pairwise distinct when done=1.
  - Outputs hold their previous values during DRAW until overwritten.
  - Consumers read outputs only when done=1.
- **Width:** slot is a 3-bit counter, range 0..5, with no wrap past 5. retry is a 4-bit counter that saturates at MAX_RETRY.

## Timing
- **Reset values:** state=IDLE, idx_a…idx_f=0, done=0, busy=0, used=0, slot=0, retry=0, lfsr=SEED.
- **Request acceptance:** req high at edge n in IDLE or DONE gives done=0 and busy=1 after edge n.
- **Draw latency**
  - First draw decision is at edge n+1.
  - Each slot needs 1..MAX_RETRY+1 decision edges.
  - done rises at the edge of the sixth store: between edge n+6 and edge n+6·(MAX_RETRY+1) (n+96 with defaults).
  - busy falls at the same edge done rises.
- **done is a level, not a pulse.** It stays high until the next accepted req or reset, so a stalled controller still sees it.
- **Reset mid-draw:** returns to the reset values at the next edge. Partial results are discarded.
- **req coinciding with the sixth store:** req is ignored; the block enters DONE. req must still be high the following cycle to restart.
- **req held high continuously in DONE:** restarts every time DONE is reached. Controllers pulse req for one cycle.

## Structure
- **Package `memory_game_pkg`:**
  - IDX_W=4, NUM_LEDS=16, NUM_SLOTS=6.
  - State encoding (IDLE, DRAW, DONE).
  - LFSR tap mask and default seed.
- **Sub-module `lfsr16`:** clk, rst, seed parameter, 16-bit state out. It is reused later for other randomized game features.
- **Top-level logic:**
  - Lowest-unused priority encoder over ~used.
  - Slot write decode.

## Test plan
- **Reset:** rst=0 for 3 cycles with random req → all outputs 0, done=0, busy=0; first cycle after release lfsr=16'hACE1.
- **Single request:** req=1 for 1 cycle → busy=1 next cycle; done=1 within 6..96 cycles; six outputs distinct and each <16. Outputs unchanged for 200 further cycles with req=0.
- **req during DRAW:** hold req=1 throughout drawing → no restart while busy. After done, next-cycle restart observed (done=0, busy=1).
- **Reset mid-draw:** rst=0 three cycles after req → next cycle done=0, busy=0, idx_a…idx_f=0. A new req completes normally.
- **Fallback path:** MAX_RETRY=0 → done exactly 6 cycles after the req edge; outputs distinct.
- **Soak:** 2000 requests with random inter-request gaps → every result distinct. Per-slot decision count ≤MAX_RETRY+1; total latency ≤96 cycles.
